// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - operand/result handshake bundle for the sequential binary-to-BCD converter
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      x;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   BCD;
  logic                  busy;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, BCD, busy
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, BCD, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one bit per cycle, IDLE/CONV/HOLD handshake
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     scr_adj;
  logic [BW-1:0]     scr_shift;

  // Add-3 correction on every digit that would overflow past 9 once doubled.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_shift = {scr_adj[BW-2:0], sr_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.x;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        scr_d = scr_shift;
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          bcd_d   = scr_shift;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.BCD       = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3)
module tb_bin2bcd_seq;
  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   x;
    logic [4*D-1:0] exp;
  } vec_t;

  function automatic logic [4*D-1:0] model(input int v);
    logic [4*D-1:0] r;
    int             n;
    r = '0;
    n = v;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] xv, output logic [4*D-1:0] got, output int lat);
    @(negedge clk);
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.x        = xv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    got = bus.BCD;
    @(posedge clk);
    #1;
    check("out_valid_one_cycle", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t           vecs[8];
    logic [4*D-1:0] got;
    logic [4*D-1:0] held;
    logic [W-1:0]   xr;
    int             lat;
    int             seen;
    int             cyc;
    int             accepted;
    int             acc_cyc[3];
    logic [W-1:0]   ops[3];
    logic [4*D-1:0] results[$];

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd100, 12'h100};
    vecs[4] = '{8'd1,   12'h001};
    vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd10,  12'h010};
    vecs[7] = '{8'd42,  12'h042};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_bcd", 32'(bus.BCD), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, got, lat);
      check("vec_latency", 32'(lat), 32'd8);
      check("vec_bcd", 32'(got), 32'(vecs[i].exp));
    end

    for (int v = 0; v < (1 << W); v++) begin
      run_op(W'(v), got, lat);
      check("sweep_bcd", 32'(got), 32'(model(v)));
      for (int d = 0; d < D; d++) begin
        if (got[4*d +: 4] > 4'd9) begin
          check("sweep_digit_range", 32'(got[4*d +: 4]), 32'd9);
        end
      end
    end

    for (int i = 0; i < 30; i++) begin
      xr = W'($urandom_range(0, (1 << W) - 1));
      run_op(xr, got, lat);
      check("rand_bcd", 32'(got), 32'(model(int'(xr))));
      check("rand_latency", 32'(lat), 32'd8);
    end

    // Backpressure: hold the result for 5 cycles with in_valid poking at it.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.x         = 8'd173;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 40) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("bp_latency", 32'(seen), 32'd8);
    held = bus.BCD;
    check("bp_bcd", 32'(held), 32'h173);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x        = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_bcd_held", 32'(bus.BCD), 32'(held));
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_bcd_retained", 32'(bus.BCD), 32'h173);

    // in_valid held high with x changing during CONV.
    @(negedge clk);
    bus.x        = 8'd37;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    seen = 0;
    while (!bus.out_valid && seen < 40) begin
      @(negedge clk);
      check("hold_in_ready_low", 32'(bus.in_ready), 32'd0);
      bus.x = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      seen++;
    end
    check("hold_bcd_first_only", 32'(bus.BCD), 32'h037);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_back_idle", 32'(bus.in_ready), 32'd1);

    // Reset at CONV iteration 4 aborts; next operand converts normally.
    @(negedge clk);
    bus.x        = 8'd200;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_bcd", 32'(bus.BCD), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(8'd42, got, lat);
    check("after_abort_bcd", 32'(got), 32'h042);
    check("after_abort_latency", 32'(lat), 32'd8);

    // Streaming with out_ready tied high.
    ops[0]   = 8'd7;
    ops[1]   = 8'd128;
    ops[2]   = 8'd250;
    accepted = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) results.push_back(bus.BCD);
      if (bus.in_ready) begin
        if (accepted < 3) begin
          bus.x           = ops[accepted];
          bus.in_valid    = 1'b1;
          acc_cyc[accepted] = cyc;
          accepted++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    check("stream_accepted", 32'(accepted), 32'd3);
    check("stream_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    check("stream_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
    check("stream_n_results", 32'(results.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < results.size()) begin
        check("stream_result", 32'(results[i]), 32'(model(int'(ops[i]))));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the binary input operand.
REQ-002 Parameter DIGITS, default 3: number of BCD digits produced; the legal pairs are (WIDTH,DIGITS) = (4,2), (8,3), (10,4), (12,4), (16,5).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  the requester presents an operand on x.
REQ-006 in_ready  output  1  the block can accept an operand.
REQ-007 x  input  WIDTH  unsigned binary operand, sampled only on acceptance.
REQ-008 out_valid  output  1  a converted result is present on BCD.
REQ-009 out_ready  input  1  the consumer accepts the result.
REQ-010 BCD  output  4*DIGITS  packed BCD result, most significant digit in the MSBs.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block shall implement a three-state FSM: IDLE, CONV, HOLD.
REQ-013 IDLE: in_ready=1 and out_valid=0; on an edge with in_valid=1, the block latches x into the shift register, clears the BCD scratch, sets iteration count=0, and moves to CONV.
REQ-014 CONV: in_ready=0; on each edge the block performs one double-dabble iteration and increments the count.
REQ-015 A double-dabble iteration shall add 3 to every scratch digit >=5, then shift {scratch, shift register} left by one bit.
REQ-016 CONV shall move to HOLD on the WIDTH-th iteration edge; the same edge loads the final scratch into the BCD output register.
REQ-017 The iteration counter shall be ceil(log2(WIDTH+1)) bits wide and shall not wrap during a conversion.
REQ-018 HOLD: out_valid=1 and in_ready=0; on an edge with out_ready=1, the transfer completes and the block moves to IDLE.
REQ-019 If out_ready=0 in HOLD, the block shall stay in HOLD with BCD and out_valid held stable for as many cycles as needed.
REQ-020 in_valid shall be ignored in CONV and HOLD; no operand is queued.
REQ-021 out_valid shall rise exactly WIDTH edges after the accepting edge (8 for the default).
REQ-022 With out_ready tied high, back-to-back conversions shall start every WIDTH+2 cycles (10 for the default).
REQ-023 The BCD output shall change only on the completion edge and shall retain the last result while in IDLE.
REQ-024 in_ready, out_valid and busy shall be decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-025 Every output digit shall be in the range 0..9 for all x in 0..2^WIDTH-1.
REQ-026 The result shall equal the decimal value of x, zero-padded to DIGITS digits.

Reset
REQ-027 While rst=0, the block shall asynchronously force state=IDLE, the counter, shift register, scratch and BCD to 0, out_valid=0, busy=0, and in_ready=1.
REQ-028 Reset asserted during CONV or HOLD shall abort the conversion; no result shall be emitted after release.
REQ-029 After rst deasserts, the first rising edge with in_valid=1 shall be accepted normally.

Verification
REQ-030 x=8'd0, in_valid pulse, out_ready=1 -> out_valid 8 edges after acceptance, BCD=12'h000, one cycle of out_valid.
REQ-031 x=8'd255 -> BCD=12'h255; x=8'd99 -> 12'h099; x=8'd100 -> 12'h100; exhaustive sweep 0..255 against the decimal model.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and BCD stay stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-033 in_valid held high with x changing during CONV -> only the first operand is converted; in_ready stays 0 until IDLE.
REQ-034 rst pulsed low at CONV iteration 4 -> immediately IDLE, BCD=0, out_valid never asserts; the next operand x=8'd42 yields 12'h042.
REQ-035 Streaming 3 operands with in_valid and out_ready tied high -> acceptances exactly 10 cycles apart, results in order.
